// File: rtl/ex_mem_stage.sv
// Execute stage of the 5-stage MIPS core: operand forwarding, ALU, iterative
// mult/div unit with HI/LO, and the EX/MEM pipeline register.
module ex_mem_stage #(
    parameter int MD_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Reg_Write_E,
    input  logic        MemToReg_E,
    input  logic        Mem_Write_E,
    input  logic        ALU_Src_E,
    input  logic        Reg_Dest_E,
    input  logic [5:0]  ALU_Con_E,
    input  logic [31:0] RegA_E,
    input  logic [31:0] RegB_E,
    input  logic [31:0] Signlmm_E,
    input  logic [4:0]  Rt_E,
    input  logic [4:0]  Rd_E,
    input  logic [4:0]  Shamt_E,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    input  logic [31:0] Result_W,
    output logic [4:0]  Write_Reg_E,
    output logic        Stall_E,
    output logic        Reg_Write_M,
    output logic        MemToReg_M,
    output logic        Mem_Write_M,
    output logic [31:0] ALU_Out_M,
    output logic [31:0] Write_Data_M,
    output logic [4:0]  Write_Reg_M
);

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    md_state_t   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] opa_q, opa_d, opb_q, opb_d;
    logic [31:0] mag_q, mag_d;
    logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [31:0] src_a, fwd_b, src_b, alu_res;
    logic        is_md, in_signed;
    logic [31:0] abs_a, abs_b;

    always_comb begin
        case (ForwardA_E)
            2'b01:   src_a = Result_W;
            2'b10:   src_a = ALU_Out_M;
            default: src_a = RegA_E;
        endcase
        case (ForwardB_E)
            2'b01:   fwd_b = Result_W;
            2'b10:   fwd_b = ALU_Out_M;
            default: fwd_b = RegB_E;
        endcase
        src_b = ALU_Src_E ? Signlmm_E : fwd_b;
    end

    assign Write_Reg_E = Reg_Dest_E ? Rd_E : Rt_E;
    assign is_md       = (ALU_Con_E[5:2] == 4'b0110);
    assign in_signed   = ~ALU_Con_E[0];
    assign abs_a       = (in_signed && src_a[31]) ? -src_a : src_a;
    assign abs_b       = (in_signed && fwd_b[31]) ? -fwd_b : fwd_b;

    always_comb begin
        alu_res = 32'd0;
        case (ALU_Con_E)
            6'h20: alu_res = src_a + src_b;
            6'h22: alu_res = src_a - src_b;
            6'h24: alu_res = src_a & src_b;
            6'h25: alu_res = src_a | src_b;
            6'h26: alu_res = src_a ^ src_b;
            6'h27: alu_res = ~(src_a | src_b);
            6'h2A: alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
            6'h2B: alu_res = {31'd0, src_a < src_b};
            6'h00: alu_res = src_b << Shamt_E;
            6'h02: alu_res = src_b >> Shamt_E;
            6'h03: alu_res = $signed(src_b) >>> Shamt_E;
            6'h10: alu_res = hi_q;
            6'h12: alu_res = lo_q;
            default: alu_res = 32'd0;
        endcase
    end

    // Iteration datapaths: mult shifts {carry,hi,lo} right, div shifts {rem,quot} left.
    logic [32:0] mul_sum, div_sh, div_diff;
    logic        div_ok;
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_q} : 33'd0);
        div_sh   = {acc_hi_q, acc_lo_q[31]};
        div_diff = div_sh - {1'b0, mag_q};
        div_ok   = ~div_diff[32];
    end

    logic        md_signed, sign_diff;
    logic [63:0] prod_fix;
    logic [31:0] fin_hi, fin_lo;
    always_comb begin
        md_signed = ~op_q[0];
        sign_diff = md_signed & (opa_q[31] ^ opb_q[31]);
        prod_fix  = sign_diff ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        fin_hi    = prod_fix[63:32];
        fin_lo    = prod_fix[31:0];
        if (op_q[1]) begin
            if (opb_q == 32'd0) begin
                fin_lo = 32'hFFFF_FFFF;
                fin_hi = opa_q;
            end else begin
                fin_lo = sign_diff ? -acc_lo_q : acc_lo_q;
                fin_hi = (md_signed && opa_q[31]) ? -acc_hi_q : acc_hi_q;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        mag_d    = mag_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (is_md) begin
                    state_d  = MD_BUSY;
                    cnt_d    = 5'd0;
                    op_d     = ALU_Con_E[1:0];
                    opa_d    = src_a;
                    opb_d    = fwd_b;
                    acc_hi_d = 32'd0;
                    acc_lo_d = ALU_Con_E[1] ? abs_a : abs_b;
                    mag_d    = ALU_Con_E[1] ? abs_b : abs_a;
                end
            end
            MD_BUSY: begin
                if (op_q[1]) begin
                    acc_hi_d = div_ok ? div_diff[31:0] : div_sh[31:0];
                    acc_lo_d = {acc_lo_q[30:0], div_ok};
                end else begin
                    acc_hi_d = mul_sum[32:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
                end
                if (cnt_q == 5'(MD_ITER - 1)) state_d = MD_DONE;
                else                          cnt_d   = cnt_q + 5'd1;
            end
            MD_DONE: begin
                hi_d    = fin_hi;
                lo_d    = fin_lo;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Reset gates the stall so the front of the pipe is released at once.
    assign Stall_E = rst & (((state_q == MD_IDLE) & is_md) | (state_q == MD_BUSY));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 2'd0;
            opa_q    <= 32'd0;
            opb_q    <= 32'd0;
            mag_q    <= 32'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            mag_q    <= mag_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Reg_Write_M  <= 1'b0;
            MemToReg_M   <= 1'b0;
            Mem_Write_M  <= 1'b0;
            ALU_Out_M    <= 32'd0;
            Write_Data_M <= 32'd0;
            Write_Reg_M  <= 5'd0;
        end else if (Stall_E) begin
            Reg_Write_M  <= 1'b0;
            MemToReg_M   <= 1'b0;
            Mem_Write_M  <= 1'b0;
        end else begin
            Reg_Write_M  <= Reg_Write_E & ~is_md;
            MemToReg_M   <= MemToReg_E;
            Mem_Write_M  <= Mem_Write_E;
            ALU_Out_M    <= alu_res;
            Write_Data_M <= fwd_b;
            Write_Reg_M  <= Write_Reg_E;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: vector table through a scoreboard,
// plus hand sequences for mult/div stalls and reset during an MD operation.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        Reg_Write_E, MemToReg_E, Mem_Write_E, ALU_Src_E, Reg_Dest_E;
    logic [5:0]  ALU_Con_E;
    logic [31:0] RegA_E, RegB_E, Signlmm_E, Result_W;
    logic [4:0]  Rt_E, Rd_E, Shamt_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic [4:0]  Write_Reg_E, Write_Reg_M;
    logic        Stall_E, Reg_Write_M, MemToReg_M, Mem_Write_M;
    logic [31:0] ALU_Out_M, Write_Data_M;

    always #5 clk = ~clk;

    ex_mem_stage #(.MD_ITER(32)) dut (
        .clk(clk), .rst(rst),
        .Reg_Write_E(Reg_Write_E), .MemToReg_E(MemToReg_E), .Mem_Write_E(Mem_Write_E),
        .ALU_Src_E(ALU_Src_E), .Reg_Dest_E(Reg_Dest_E), .ALU_Con_E(ALU_Con_E),
        .RegA_E(RegA_E), .RegB_E(RegB_E), .Signlmm_E(Signlmm_E),
        .Rt_E(Rt_E), .Rd_E(Rd_E), .Shamt_E(Shamt_E),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .Result_W(Result_W),
        .Write_Reg_E(Write_Reg_E), .Stall_E(Stall_E),
        .Reg_Write_M(Reg_Write_M), .MemToReg_M(MemToReg_M), .Mem_Write_M(Mem_Write_M),
        .ALU_Out_M(ALU_Out_M), .Write_Data_M(Write_Data_M), .Write_Reg_M(Write_Reg_M)
    );

    typedef struct {
        logic [5:0]  fn;
        logic [31:0] a, b, imm;
        logic        src, dst;
        logic [4:0]  rt, rd, sh;
        logic [1:0]  fa, fb;
        logic [31:0] rw;
        logic [2:0]  ctl;
        logic [31:0] exp_alu, exp_wd;
        logic [4:0]  exp_wr;
    } vec_t;

    typedef struct {
        logic [31:0] alu, wd;
        logic [4:0]  wr;
        logic [2:0]  ctl;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mkv(input logic [5:0] fn, input logic [31:0] a, b, imm,
                                 input logic src, dst, input logic [4:0] rt, rd, sh,
                                 input logic [1:0] fa, fb, input logic [31:0] rw,
                                 input logic [2:0] ctl, input logic [31:0] ea, ewd,
                                 input logic [4:0] ewr);
        vec_t v;
        v.fn = fn; v.a = a; v.b = b; v.imm = imm; v.src = src; v.dst = dst;
        v.rt = rt; v.rd = rd; v.sh = sh; v.fa = fa; v.fb = fb; v.rw = rw;
        v.ctl = ctl; v.exp_alu = ea; v.exp_wd = ewd; v.exp_wr = ewr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        ALU_Con_E = v.fn; RegA_E = v.a; RegB_E = v.b; Signlmm_E = v.imm;
        ALU_Src_E = v.src; Reg_Dest_E = v.dst; Rt_E = v.rt; Rd_E = v.rd;
        Shamt_E = v.sh; ForwardA_E = v.fa; ForwardB_E = v.fb; Result_W = v.rw;
        {Reg_Write_E, MemToReg_E, Mem_Write_E} = v.ctl;
    endtask

    task automatic check_out(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({nm, " alu_out_m"}, ALU_Out_M, e.alu);
            chk({nm, " write_data_m"}, Write_Data_M, e.wd);
            chk({nm, " write_reg_m"}, 32'(Write_Reg_M), 32'(e.wr));
            chk({nm, " ctl_m"}, 32'({Reg_Write_M, MemToReg_M, Mem_Write_M}), 32'(e.ctl));
        end
        $display("txn %s: alu=%h wd=%h wr=%0d ctl=%b", nm, ALU_Out_M, Write_Data_M,
                 Write_Reg_M, {Reg_Write_M, MemToReg_M, Mem_Write_M});
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " stall"}, 32'(Stall_E), 32'd0);
        chk({nm, " alu_out_m"}, ALU_Out_M, 32'd0);
        chk({nm, " write_data_m"}, Write_Data_M, 32'd0);
        chk({nm, " write_reg_m"}, 32'(Write_Reg_M), 32'd0);
        chk({nm, " ctl_m"}, 32'({Reg_Write_M, MemToReg_M, Mem_Write_M}), 32'd0);
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        drive(v);
        #1;
        chk({nm, " write_reg_e"}, 32'(Write_Reg_E), 32'(v.exp_wr));
        chk({nm, " stall_e"}, 32'(Stall_E), 32'd0);
        sb.push_back('{v.exp_alu, v.exp_wd, v.exp_wr, 3'b000 | v.ctl});
        @(posedge clk);
        #1;
        check_out(nm);
    endtask

    task automatic run_md(input logic [5:0] fn, input logic [31:0] a, b,
                          input logic [31:0] exp_hi, exp_lo, input string nm);
        int   stalls;
        logic done;
        stalls = 0;
        done   = 1'b0;
        @(negedge clk);
        drive(mkv(fn, a, b, 32'd0, 1'b0, 1'b1, 5'd0, 5'd20, 5'd0, 2'b00, 2'b00,
                  32'd0, 3'b100, 32'd0, b, 5'd20));
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (Stall_E) begin
                stalls++;
                @(posedge clk);
                #1;
                if ({Reg_Write_M, MemToReg_M, Mem_Write_M} !== 3'b000)
                    chk({nm, " bubble_ctl"}, 32'({Reg_Write_M, MemToReg_M, Mem_Write_M}), 32'd0);
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        chk({nm, " stall_cycles"}, 32'(stalls), 32'd33);
        sb.push_back('{32'd0, b, 5'd20, 3'b000});
        @(posedge clk);
        #1;
        check_out({nm, " retire"});
        apply(mkv(6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd8, 5'd0, 2'b00, 2'b00,
                  32'd0, 3'b100, exp_hi, 32'd0, 5'd8), {nm, " mfhi"});
        apply(mkv(6'h12, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd9, 5'd0, 2'b00, 2'b00,
                  32'd0, 3'b100, exp_lo, 32'd0, 5'd9), {nm, " mflo"});
    endtask

    vec_t nop;

    initial begin
        nop = mkv(6'h3F, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00,
                  32'd0, 3'b000, 32'd0, 32'd0, 5'd0);
        //        fn     a             b             imm           src  dst  rt  rd  sh  fa     fb     rw          ctl     alu           wd            wr
        vecs.push_back(mkv(6'h20, 32'd5,        32'd7,        32'd0, 1'b0, 1'b1, 5'd1, 5'd3, 5'd0, 2'b00, 2'b00, 32'd0, 3'b100, 32'd12, 32'd7, 5'd3));
        vecs.push_back(mkv(6'h25, 32'h100,      32'd0,        32'd0, 1'b0, 1'b0, 5'd4, 5'd9, 5'd0, 2'b00, 2'b00, 32'd0, 3'b100, 32'h100, 32'd0, 5'd4));
        vecs.push_back(mkv(6'h22, 32'hDEAD,     32'h10,       32'd0, 1'b0, 1'b1, 5'd2, 5'd5, 5'd0, 2'b10, 2'b00, 32'd0, 3'b100, 32'hF0, 32'h10, 5'd5));
        vecs.push_back(mkv(6'h20, 32'd1,        32'h55,       32'd0, 1'b0, 1'b1, 5'd0, 5'd6, 5'd0, 2'b00, 2'b01, 32'd9, 3'b100, 32'd10, 32'd9, 5'd6));
        vecs.push_back(mkv(6'h03, 32'd0,        32'h80000000, 32'd0, 1'b0, 1'b1, 5'd0, 5'd7, 5'd4, 2'b00, 2'b00, 32'd0, 3'b100, 32'hF8000000, 32'h80000000, 5'd7));
        vecs.push_back(mkv(6'h2A, 32'hFFFFFFFF, 32'd1,        32'd0, 1'b0, 1'b1, 5'd0, 5'd10, 5'd0, 2'b00, 2'b00, 32'd0, 3'b100, 32'd1, 32'd1, 5'd10));
        vecs.push_back(mkv(6'h2B, 32'hFFFFFFFF, 32'd1,        32'd0, 1'b0, 1'b0, 5'd11, 5'd2, 5'd0, 2'b00, 2'b00, 32'd0, 3'b100, 32'd0, 32'd1, 5'd11));
        vecs.push_back(mkv(6'h2A, 32'd1,        32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 5'd0, 5'd13, 5'd0, 2'b00, 2'b00, 32'd0, 3'b100, 32'd0, 32'hFFFFFFFF, 5'd13));
        vecs.push_back(mkv(6'h20, 32'd10,       32'd3,  32'hFFFFFFFE, 1'b1, 1'b0, 5'd12, 5'd1, 5'd0, 2'b00, 2'b00, 32'd0, 3'b001, 32'd8, 32'd3, 5'd12));
        vecs.push_back(mkv(6'h00, 32'd0,        32'd1,        32'd0, 1'b0, 1'b1, 5'd0, 5'd14, 5'd31, 2'b00, 2'b00, 32'd0, 3'b100, 32'h80000000, 32'd1, 5'd14));
        vecs.push_back(mkv(6'h02, 32'd0,        32'h80000001, 32'd0, 1'b0, 1'b1, 5'd0, 5'd15, 5'd1, 2'b00, 2'b00, 32'd0, 3'b100, 32'h40000000, 32'h80000001, 5'd15));
        vecs.push_back(mkv(6'h27, 32'd0,        32'd0,        32'd0, 1'b0, 1'b1, 5'd0, 5'd16, 5'd0, 2'b00, 2'b00, 32'd0, 3'b100, 32'hFFFFFFFF, 32'd0, 5'd16));
        vecs.push_back(mkv(6'h26, 32'hF0F0,     32'hFF00,     32'd0, 1'b0, 1'b1, 5'd0, 5'd17, 5'd0, 2'b00, 2'b00, 32'd0, 3'b100, 32'h0FF0, 32'hFF00, 5'd17));
        vecs.push_back(mkv(6'h24, 32'hF0F0,     32'hFF00,     32'd0, 1'b0, 1'b1, 5'd0, 5'd18, 5'd0, 2'b00, 2'b00, 32'd0, 3'b100, 32'hF000, 32'hFF00, 5'd18));
        vecs.push_back(mkv(6'h3F, 32'd5,        32'd6,        32'd0, 1'b0, 1'b1, 5'd0, 5'd19, 5'd0, 2'b00, 2'b00, 32'd0, 3'b010, 32'd0, 32'd6, 5'd19));
        vecs.push_back(mkv(6'h20, 32'd2,        32'd3,        32'd0, 1'b0, 1'b1, 5'd0, 5'd21, 5'd0, 2'b11, 2'b00, 32'd0, 3'b100, 32'd5, 32'd3, 5'd21));
        vecs.push_back(mkv(6'h20, 32'd1,        32'd100,      32'd0, 1'b0, 1'b1, 5'd0, 5'd22, 5'd0, 2'b00, 2'b10, 32'd0, 3'b100, 32'd6, 32'd5, 5'd22));
        vecs.push_back(mkv(6'h20, 32'd7,        32'd2,        32'd0, 1'b0, 1'b1, 5'd0, 5'd23, 5'd0, 2'b01, 2'b00, 32'h20, 3'b100, 32'h22, 32'd2, 5'd23));
        vecs.push_back(mkv(6'h22, 32'd0,        32'd1,        32'd0, 1'b0, 1'b1, 5'd0, 5'd24, 5'd0, 2'b00, 2'b00, 32'd0, 3'b100, 32'hFFFFFFFF, 32'd1, 5'd24));

        // Reset held with an MD op in E: outputs cleared, no stall.
        rst = 1'b0;
        drive(mkv(6'h18, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 5'd0, 5'd1, 5'd0, 2'b00, 2'b00,
                  32'd0, 3'b111, 32'd0, 32'd0, 5'd0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_zero("reset_hold");
        drive(nop);
        rst = 1'b1;

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        run_md(6'h18, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult");
        run_md(6'h19, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, "multu");
        run_md(6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
        run_md(6'h1B, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, "divu0");

        // Reset ten cycles into a mult: abort, no HI/LO update.
        @(negedge clk);
        drive(mkv(6'h18, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 5'd0, 5'd2, 5'd0, 2'b00, 2'b00,
                  32'd0, 3'b100, 32'd0, 32'd0, 5'd2));
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        chk("busy_before_reset stall", 32'(Stall_E), 32'd1);
        rst = 1'b0;
        #1;
        check_zero("reset_busy");
        drive(nop);
        @(negedge clk);
        rst = 1'b1;
        apply(mkv(6'h10, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd8, 5'd0, 2'b00, 2'b00,
                  32'd0, 3'b100, 32'd0, 32'd0, 5'd8), "post_reset mfhi");
        apply(mkv(6'h12, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd9, 5'd0, 2'b00, 2'b00,
                  32'd0, 3'b100, 32'd0, 32'd0, 5'd9), "post_reset mflo");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
